text_plane_ctrl: RTL and testbench

Character-cell text plane controller for the 5x7 font video path. It arbitrates single-character writes from NREQ requesters into an internal COLS x ROWS character buffer, and runs a clear sequencer. During scanout it reads the buffered ASCII code for the current font cell and selects the matching 256-bit font pel to produce a 1-bit overlay pixel. It sits between the font generator outputs (char_x, char_y, ascii_char) and the video mixer.

---
 rtl/text_plane_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_text_plane_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_plane_ctrl.sv
// text_plane_ctrl
//   Character-cell text plane: round-robin arbitration of single-character
//   writes from NREQ requesters into a COLS x ROWS character buffer, a clear
//   sequencer, and a 2-cycle scanout pipeline that turns the buffered code of
//   the current font cell into a 1-bit overlay pixel.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   per-requester write handshake (write on valid&ready)
//   req_x/req_y/req_char  packed per-requester fields, requester i at [i*8+:8]
//   clear                 pulse: fill buffer with CLR_CHAR
//   busy                  clear sequencer running
//   char_x/char_y         font-generator cell being scanned
//   ascii_char            font pel for every ASCII code, aligned with char_x/y
//   out                   overlay pixel, 2 cycles after char_x/char_y
//   drop_cnt              saturating count of granted out-of-range writes
module text_plane_ctrl #(
    parameter int         NREQ     = 2,
    parameter int         COLS     = 40,
    parameter int         ROWS     = 30,
    parameter logic [7:0] CLR_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_x,
    input  logic [NREQ*8-1:0] req_y,
    input  logic [NREQ*8-1:0] req_char,
    input  logic              clear,
    output logic              busy,
    input  logic [7:0]        char_x,
    input  logic [7:0]        char_y,
    input  logic [255:0]      ascii_char,
    output logic              out,
    output logic [7:0]        drop_cnt
);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_addr;
    logic          clr_last, clr_we, arb_en;

    logic [PW-1:0] ptr, gnt_idx, hi_idx, lo_idx;
    logic          hi_hit, lo_hit, gnt;
    logic [7:0]    sel_x, sel_y, sel_c;
    logic          wr_in_range;

    logic [7:0]    mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [7:0]    mem_wd;

    logic          rd_in_range;
    logic [AW-1:0] rd_addr;
    logic [7:0]    s1_code;
    logic          s1_in, s1_busy;
    logic [255:0]  s1_pel;

    assign clr_last = (clr_addr == AW'(DEPTH - 1));

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (clear)    state_nxt = S_CLEAR;
            S_CLEAR: if (clr_last) state_nxt = S_IDLE;
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        busy   = (state == S_CLEAR);
        clr_we = (state == S_CLEAR);
        // Arbitration is suppressed on the cycle a clear is requested so no
        // write can land in the buffer after the clear has been accepted.
        arb_en = (state == S_IDLE) && !clear && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset)                  clr_addr <= '0;
        else if (state == S_CLEAR)  clr_addr <= clr_last ? '0 : clr_addr + AW'(1);
    end

    // ---------------- round-robin arbiter ----------------
    // hi_* finds the lowest valid requester at or above the pointer, lo_* the
    // lowest valid overall; lo_* is the wrap-around fallback.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_hit = 1'b1;
                lo_idx = PW'(i);
            end
            if (req_valid[i] && (PW'(i) >= ptr)) begin
                hi_hit = 1'b1;
                hi_idx = PW'(i);
            end
        end
        gnt       = arb_en && lo_hit;
        gnt_idx   = hi_hit ? hi_idx : lo_idx;
        req_ready = gnt ? (NREQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == gnt_idx) begin
                sel_x = req_x[i*8 +: 8];
                sel_y = req_y[i*8 +: 8];
                sel_c = req_char[i*8 +: 8];
            end
        end
        wr_in_range = (int'(sel_x) < COLS) && (int'(sel_y) < ROWS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            drop_cnt <= '0;
        end else if (gnt) begin
            ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
            if (!wr_in_range && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // ---------------- character buffer ----------------
    // Clear and requester writes never coincide: grants only happen in IDLE.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = CLR_CHAR;
        if (clr_we) begin
            mem_we = 1'b1;
            mem_wa = clr_addr;
        end else if (gnt && wr_in_range) begin
            mem_we = 1'b1;
            mem_wa = AW'(int'(sel_y) * COLS + int'(sel_x));
            mem_wd = sel_c;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // ---------------- scanout pipeline ----------------
    // Stage 1 reads the buffer with non-blocking semantics, so a same-cycle
    // write to the same cell yields the old code (read-before-write).
    always_comb begin
        rd_in_range = (int'(char_x) < COLS) && (int'(char_y) < ROWS);
        rd_addr     = rd_in_range ? AW'(int'(char_y) * COLS + int'(char_x)) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_code <= '0;
            s1_in   <= 1'b0;
            s1_busy <= 1'b0;
            s1_pel  <= '0;
            out     <= 1'b0;
        end else begin
            s1_code <= mem[rd_addr];
            s1_in   <= rd_in_range;
            s1_busy <= busy;
            s1_pel  <= ascii_char;
            out     <= s1_in && !s1_busy && s1_pel[s1_code];
        end
    end
endmodule

// File: tb/tb_text_plane_ctrl.sv
module tb_text_plane_ctrl;
    localparam int         NREQ  = 2;
    localparam int         COLS  = 40;
    localparam int         ROWS  = 30;
    localparam int         DEPTH = COLS * ROWS;
    localparam logic [7:0] CLR   = 8'h20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_x = '0, req_y = '0, req_char = '0;
    logic              clear = 1'b0;
    logic              busy;
    logic [7:0]        char_x = '0, char_y = '0;
    logic [255:0]      ascii_char = '0;
    logic              out;
    logic [7:0]        drop_cnt;

    always #5 clk = ~clk;

    text_plane_ctrl #(.NREQ(NREQ), .COLS(COLS), .ROWS(ROWS), .CLR_CHAR(CLR)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_char(req_char),
        .clear(clear), .busy(busy),
        .char_x(char_x), .char_y(char_y), .ascii_char(ascii_char),
        .out(out), .drop_cnt(drop_cnt)
    );

    int   checks = 0, errors = 0;

    // Reference model: buffer contents (-1 = unknown), remaining clear cycles,
    // round-robin pointer, drop count and the expected-out pipeline.
    int   mmem [DEPTH];
    int   clr_rem = DEPTH, ptr = 0, drop = 0, last_gnt = -1;
    logic e1 = 1'b0, e2 = 1'b0;

    typedef struct {
        logic [7:0] cx;
        logic [7:0] cy;
        logic [7:0] code;
        logic       exp;
    } scan_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare outputs at the falling edge, advance the model at the
    // rising edge, return 1 time unit after it.
    task automatic tick();
        int   g, cx, cy, x, y;
        logic e;
        g = -1;
        e = 1'b0;
        @(negedge clk);
        if (!reset) begin
            if (clr_rem == 0 && !clear)
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            chk("ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
            chk("busy", 32'(busy), 32'(clr_rem > 0));
            chk("out", 32'(out), 32'(e2));
            chk("drop", 32'(drop_cnt), 32'(drop));
            cx = int'(char_x);
            cy = int'(char_y);
            if (cx < COLS && cy < ROWS && clr_rem == 0) e = ascii_char[mmem[cy*COLS + cx]];
        end
        last_gnt = g;
        @(posedge clk);
        if (reset) begin
            clr_rem = DEPTH; ptr = 0; drop = 0; e1 = 1'b0; e2 = 1'b0;
            for (int i = 0; i < DEPTH; i++) mmem[i] = -1;
        end else begin
            e2 = e1;
            e1 = e;
            if (clr_rem > 0) begin
                mmem[DEPTH - clr_rem] = int'(CLR);
                clr_rem--;
            end else if (clear) begin
                clr_rem = DEPTH;
            end
            if (g >= 0) begin
                ptr = (g + 1) % NREQ;
                x = int'(req_x[g*8 +: 8]);
                y = int'(req_y[g*8 +: 8]);
                if (x < COLS && y < ROWS) mmem[y*COLS + x] = int'(req_char[g*8 +: 8]);
                else if (drop < 255) drop++;
            end
        end
        #1;
    endtask

    // Drive a cell with a single lit font code and check out 2 cycles later.
    task automatic scan(input string nm, input logic [7:0] cx, input logic [7:0] cy,
                        input logic [7:0] code, input logic exp);
        char_x = cx;
        char_y = cy;
        ascii_char = '0;
        ascii_char[code] = 1'b1;
        tick();
        tick();
        chk(nm, 32'(out), 32'(exp));
    endtask

    task automatic do_reset();
        int n, acc;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n = 0;
        acc = 0;
        for (int i = 0; i < 2000 && busy; i++) begin
            n++;
            if (out) acc++;
            tick();
        end
        chk("reset_busy_len", 32'(n), 32'(DEPTH));
        chk("reset_out_zero", 32'(acc), 32'd0);
    endtask

    initial begin
        scan_vec_t tbl [8];
        int n, rh, acc;

        // ---- reset, auto-clear, blank scan ----
        ascii_char = '1;
        do_reset();
        chk("drop_after_reset", 32'(drop_cnt), 32'd0);
        ascii_char = '1;
        ascii_char[8'h20] = 1'b0;
        acc = 0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                char_x = 8'(x);
                char_y = 8'(y);
                tick();
                if (out) acc++;
            end
        tick(); if (out) acc++;
        tick(); if (out) acc++;
        chk("blank_scan", 32'(acc), 32'd0);

        // ---- round robin: both requesters valid for 6 cycles ----
        req_valid = 2'b11;
        req_x = {8'd11, 8'd10};
        req_y = {8'd10, 8'd10};
        req_char = {8'h62, 8'h61};
        for (int i = 0; i < 6; i++) begin
            #1 chk("rr_grant", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        req_valid = '0;

        // ---- write 'A' at (3,2) from requester 0 ----
        req_valid = 2'b01;
        req_x[7:0] = 8'd3; req_y[7:0] = 8'd2; req_char[7:0] = 8'h41;
        #1 chk("wrA_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;

        // ---- out-of-range writes from requester 1 ----
        req_valid = 2'b10;
        req_x[15:8] = 8'd40; req_y[15:8] = 8'd0; req_char[15:8] = 8'h58;
        #1 chk("oor1_ready", 32'(req_ready), 32'd2);
        tick();
        req_x[15:8] = 8'd0; req_y[15:8] = 8'd30;
        #1 chk("oor2_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        chk("drop_two", 32'(drop_cnt), 32'd2);

        // ---- table-driven scan vectors ----
        tbl[0] = '{8'd3,  8'd2,  8'h41, 1'b1};
        tbl[1] = '{8'd4,  8'd2,  8'h41, 1'b0};
        tbl[2] = '{8'd4,  8'd2,  8'h20, 1'b1};
        tbl[3] = '{8'd3,  8'd2,  8'h20, 1'b0};
        tbl[4] = '{8'd40, 8'd2,  8'h20, 1'b0};
        tbl[5] = '{8'd3,  8'd30, 8'h20, 1'b0};
        tbl[6] = '{8'd0,  8'd0,  8'h20, 1'b1};
        tbl[7] = '{8'd11, 8'd10, 8'h62, 1'b1};
        for (int i = 0; i < 8; i++) scan($sformatf("tbl%0d", i), tbl[i].cx, tbl[i].cy, tbl[i].code, tbl[i].exp);

        // ---- drop counter saturation ----
        req_valid = 2'b10;
        for (int i = 0; i < 300; i++) begin
            req_x[15:8] = 8'($urandom_range(40, 255));
            tick();
        end
        req_valid = '0;
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // ---- clear pulse with a pending request, second pulse ignored ----
        req_valid = 2'b01;
        req_x[7:0] = 8'd1; req_y[7:0] = 8'd1; req_char[7:0] = 8'h42;
        clear = 1'b1;
        #1 chk("clr_ready0", 32'(req_ready), 32'd0);
        tick();
        clear = 1'b0;
        n = 0;
        rh = 0;
        for (int i = 0; i < 2000 && busy; i++) begin
            if (req_ready != '0) rh++;
            n++;
            if (i == 500) clear = 1'b1;
            tick();
            clear = 1'b0;
        end
        chk("clr_busy_len", 32'(n), 32'(DEPTH));
        chk("clr_ready_hi", 32'(rh), 32'd0);
        req_valid = '0;
        scan("clrA_old", 8'd3, 8'd2, 8'h41, 1'b0);
        scan("clrA_new", 8'd3, 8'd2, 8'h20, 1'b1);

        // ---- write/read collision at (5,5) ----
        char_x = 8'd5; char_y = 8'd5;
        ascii_char = '0;
        ascii_char[8'h20] = 1'b1;
        req_valid = 2'b01;
        req_x[7:0] = 8'd5; req_y[7:0] = 8'd5; req_char[7:0] = 8'h5A;
        tick();
        req_valid = '0;
        tick();
        chk("coll_old", 32'(out), 32'd1);
        tick();
        chk("coll_new", 32'(out), 32'd0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3500; i++) begin
            reset = (i >= 200 && i < 203);
            req_valid = NREQ'($urandom);
            for (int r = 0; r < NREQ; r++) begin
                req_x[r*8 +: 8] = 8'($urandom_range(0, 47));
                req_y[r*8 +: 8] = 8'($urandom_range(0, 35));
                req_char[r*8 +: 8] = 8'($urandom);
            end
            clear = ($urandom_range(0, 999) == 0);
            char_x = 8'($urandom_range(0, 44));
            char_y = 8'($urandom_range(0, 33));
            for (int w = 0; w < 8; w++) ascii_char[w*32 +: 32] = $urandom;
            tick();
        end
        reset = 1'b0;
        clear = 1'b0;
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end
endmodule
